dmem_port_arbiter: RTL and testbench

// - Shares the single-port data-memory BRAM between the core MEM stage and the PS host loader/debug port.
// - Arbitrates one access per cycle, aligns stores into byte-lane write enables, and tracks in-flight reads.
// - Returns each read's data to its originator after the fixed BRAM latency.
// - Sits between mem_stage and the BRAM wrapper, replacing the direct MEM-stage BRAM hookup.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_store_align.sv | 48 ++++
 rtl/dmem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types for the data-memory port arbiter.
//   owner_e    : which requester issued an access (core MEM stage or host).
//   mem_size_e : core access size encoding (2'b11 is handled as a word).
//   rd_tag_t   : per-load tracking record carried down the read-return pipe.
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_HOST = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } mem_size_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   misalign;
   } rd_tag_t;

endpackage : dmem_pkg

// File: rtl/dmem_store_align.sv
// ---------------------------------------------------------------------------
// dmem_store_align
// Purely combinational store-lane alignment for core accesses.
// Ports:
//   i_size     : access size (00 byte, 01 half, 10/11 word)
//   i_addr_lo  : byte offset within the word (addr[1:0])
//   i_wdata    : right-justified store data
//   o_we       : byte-lane write enables for an aligned store
//   o_wdata    : store data replicated across the lanes
//   o_misalign : access does not fall on its natural boundary
// ---------------------------------------------------------------------------
module dmem_store_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_we,
   output logic [31:0] o_wdata,
   output logic        o_misalign
);

   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a value unassigned, which would otherwise infer a latch.
      o_we       = 4'b1111;
      o_wdata    = i_wdata;
      o_misalign = 1'b0;
      case (i_size)
         SZ_B: begin
            o_we    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
         end
         SZ_H: begin
            o_we       = 4'b0011 << {i_addr_lo[1], 1'b0};
            o_wdata    = {2{i_wdata[15:0]}};
            o_misalign = i_addr_lo[0];
         end
         default: begin
            // word and the reserved 2'b11 encoding
            o_we       = 4'b1111;
            o_wdata    = i_wdata;
            o_misalign = |i_addr_lo;
         end
      endcase
   end

endmodule : dmem_store_align

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-port data BRAM between the core MEM stage and the host
// loader/debug port. One access is issued per cycle; load results are routed
// back to their originator RD_LAT cycles after the grant.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   core_req/we/size/addr/wdata -> core_gnt, core_rvalid, core_rdata,
//                           core_misalign (suppressed misaligned access)
//   host_req/we/be/addr/wdata   -> host_gnt, host_rvalid, host_rdata
//   mem_we, mem_addr, mem_wdata : BRAM request side (word address)
//   mem_rdata            : BRAM read data, RD_LAT cycles after the address
// ---------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [1:0]        core_size,
   input  logic [31:0]       core_addr,
   input  logic [31:0]       core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [31:0]       core_rdata,
   output logic              core_misalign,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [3:0]        host_be,
   input  logic [31:0]       host_addr,
   input  logic [31:0]       host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [31:0]       host_rdata,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // ------------------------------------------------------------------
   // Arbitration: r_last_owner records who won last; on contention the
   // other side wins. Reset value HOST means core is favoured first.
   // Grants are gated by rst_n so nothing issues while reset is held.
   // ------------------------------------------------------------------
   owner_e r_last_owner;
   logic   w_core_gnt;
   logic   w_host_gnt;

   assign w_core_gnt = rst_n & core_req & (~host_req | (r_last_owner == OWN_HOST));
   assign w_host_gnt = rst_n & host_req & ~w_core_gnt;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n)          r_last_owner <= OWN_HOST;
      else if (w_core_gnt) r_last_owner <= OWN_CORE;
      else if (w_host_gnt) r_last_owner <= OWN_HOST;
   end

   // ------------------------------------------------------------------
   // Core store alignment
   // ------------------------------------------------------------------
   logic [3:0]  w_align_we;
   logic [31:0] w_align_wdata;
   logic        w_align_mis;

   dmem_store_align u_store_align (
      .i_size     (core_size),
      .i_addr_lo  (core_addr[1:0]),
      .i_wdata    (core_wdata),
      .o_we       (w_align_we),
      .o_wdata    (w_align_wdata),
      .o_misalign (w_align_mis)
   );

   // ------------------------------------------------------------------
   // Issue mux. Address and write data hold their last issued value when
   // no access is granted.
   // ------------------------------------------------------------------
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [ADDR_W-1:0] w_issue_addr;
   logic [31:0]       w_issue_wdata;
   logic [3:0]        w_issue_we;
   rd_tag_t           w_issue_tag;

   always_comb begin
      w_issue_addr  = r_mem_addr;
      w_issue_wdata = r_mem_wdata;
      w_issue_we    = 4'b0000;
      w_issue_tag   = '0;
      if (w_core_gnt) begin
         w_issue_addr = core_addr[ADDR_W+1:2];
         if (core_we) begin
            w_issue_wdata = w_align_wdata;
            w_issue_we    = w_align_mis ? 4'b0000 : w_align_we;
         end else begin
            w_issue_tag = '{valid: 1'b1, owner: OWN_CORE, misalign: w_align_mis};
         end
      end else if (w_host_gnt) begin
         w_issue_addr = host_addr[ADDR_W+1:2];
         if (host_we) begin
            w_issue_wdata = host_wdata;
            w_issue_we    = host_be;
         end else begin
            w_issue_tag = '{valid: 1'b1, owner: OWN_HOST, misalign: 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_addr  <= w_issue_addr;
         r_mem_wdata <= w_issue_wdata;
      end
   end

   assign mem_we        = w_issue_we;
   assign mem_addr      = rst_n ? w_issue_addr  : '0;
   assign mem_wdata     = rst_n ? w_issue_wdata : '0;
   assign core_gnt      = w_core_gnt;
   assign host_gnt      = w_host_gnt;
   assign core_misalign = w_core_gnt & w_align_mis;

   // ------------------------------------------------------------------
   // Read-return tracking: one tag per issued load, aligned with the
   // BRAM latency so the last stage lines up with mem_rdata.
   // ------------------------------------------------------------------
   rd_tag_t r_tag [RD_LAT];

   always_ff @(posedge clk) begin
      // NOTE: the tag stages are reset (not left as plain storage) because
      // stale valid bits would emit rvalids for loads issued before reset.
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) r_tag[i] <= '0;
      end else begin
         r_tag[0] <= w_issue_tag;
         for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   rd_tag_t     w_ret;
   logic        w_core_ret;
   logic        w_host_ret;
   logic [31:0] w_core_ret_data;
   logic [31:0] r_core_rdata;
   logic [31:0] r_host_rdata;

   assign w_ret           = r_tag[RD_LAT-1];
   assign w_core_ret      = rst_n & w_ret.valid & (w_ret.owner == OWN_CORE);
   assign w_host_ret      = rst_n & w_ret.valid & (w_ret.owner == OWN_HOST);
   // A suppressed (misaligned) load still completes, but with zero data.
   assign w_core_ret_data = w_ret.misalign ? 32'h0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_core_rdata <= '0;
         r_host_rdata <= '0;
      end else begin
         if (w_core_ret) r_core_rdata <= w_core_ret_data;
         if (w_host_ret) r_host_rdata <= mem_rdata;
      end
   end

   assign core_rvalid = w_core_ret;
   assign host_rvalid = w_host_ret;
   assign core_rdata  = !rst_n ? 32'h0 : (w_core_ret ? w_core_ret_data : r_core_rdata);
   assign host_rdata  = !rst_n ? 32'h0 : (w_host_ret ? mem_rdata       : r_host_rdata);

   // Address bits outside the BRAM word range are intentionally ignored.
   logic w_unused;
   assign w_unused = ^{core_addr[31:ADDR_W+2], host_addr[31:ADDR_W+2], host_addr[1:0]};

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter. Two instances share all inputs:
// u_dut1 with RD_LAT = 1 and u_dut2 with RD_LAT = 2. A small BRAM model,
// addressed from u_dut1, feeds each instance read data at its own latency.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        core_req, core_we;
   logic [1:0]  core_size;
   logic [31:0] core_addr, core_wdata;
   logic        host_req, host_we;
   logic [3:0]  host_be;
   logic [31:0] host_addr, host_wdata;

   logic        c1_gnt, c1_rvalid, c1_mis, h1_gnt, h1_rvalid;
   logic [31:0] c1_rdata, h1_rdata, m1_wdata, m1_rdata;
   logic [3:0]  m1_we;
   logic [9:0]  m1_addr;

   logic        c2_gnt, c2_rvalid, c2_mis, h2_gnt, h2_rvalid;
   logic [31:0] c2_rdata, h2_rdata, m2_wdata, m2_rdata;
   logic [3:0]  m2_we;
   logic [9:0]  m2_addr;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(10), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_size(core_size),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(c1_gnt), .core_rvalid(c1_rvalid), .core_rdata(c1_rdata),
      .core_misalign(c1_mis),
      .host_req(host_req), .host_we(host_we), .host_be(host_be),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(h1_gnt), .host_rvalid(h1_rvalid), .host_rdata(h1_rdata),
      .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .mem_rdata(m1_rdata)
   );

   dmem_port_arbiter #(.ADDR_W(10), .RD_LAT(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_size(core_size),
      .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(c2_gnt), .core_rvalid(c2_rvalid), .core_rdata(c2_rdata),
      .core_misalign(c2_mis),
      .host_req(host_req), .host_we(host_we), .host_be(host_be),
      .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(h2_gnt), .host_rvalid(h2_rvalid), .host_rdata(h2_rdata),
      .mem_we(m2_we), .mem_addr(m2_addr), .mem_wdata(m2_wdata),
      .mem_rdata(m2_rdata)
   );

   // ---------------- BRAM model ----------------
   // Initial contents: word k = 0xD15C0000 + k*0x111 (loaded on first edge).
   logic [31:0] mem [1024];
   bit          init_done = 1'b0;
   logic [31:0] rd_d0, rd_d1;

   always @(posedge clk) begin
      if (!init_done) begin
         for (int k = 0; k < 1024; k++) mem[k] <= 32'hD15C_0000 + 32'(k) * 32'h111;
         init_done <= 1'b1;
      end else begin
         for (int b = 0; b < 4; b++)
            if (m1_we[b]) mem[m1_addr][8*b +: 8] <= m1_wdata[8*b +: 8];
      end
      rd_d0 <= mem[m1_addr];
      rd_d1 <= rd_d0;
   end

   assign m1_rdata = rd_d0;
   assign m2_rdata = rd_d1;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic idle();
      core_req = 1'b0; core_we = 1'b0; core_size = 2'b10;
      core_addr = '0;  core_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_be = 4'b0000;
      host_addr = '0;  host_wdata = '0;
   endtask

   task automatic core_acc(input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] d);
      core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wdata = d;
   endtask

   task automatic host_acc(input logic we, input logic [3:0] be,
                           input logic [31:0] a, input logic [31:0] d);
      host_req = 1'b1; host_we = we; host_be = be; host_addr = a; host_wdata = d;
   endtask

   // Advance to the next falling edge: apply stimulus there, sample at +1.
   task automatic next_cycle();
      @(negedge clk);
      idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);

      // Requests while reset is held must not be granted.
      core_acc(1'b0, 2'b10, 32'h10, 32'h0);
      host_acc(1'b0, 4'h0, 32'h20, 32'h0);
      #1;
      check("rst_core_gnt",  32'(c1_gnt), 32'h0);
      check("rst_host_gnt",  32'(h1_gnt), 32'h0);
      check("rst_mem_we",    32'(m1_we), 32'h0);
      check("rst_mem_addr",  32'(m1_addr), 32'h0);
      check("rst_mem_wdata", m1_wdata, 32'h0);
      check("rst_core_rv",   32'(c1_rvalid), 32'h0);
      check("rst_core_rd",   c1_rdata, 32'h0);
      check("rst_host_rd",   h1_rdata, 32'h0);
      check("rst_mis",       32'(c1_mis), 32'h0);

      next_cycle(); rst_n = 1'b1;

      // Core lone sb 0xA5 to 0x103
      next_cycle(); core_acc(1'b1, 2'b00, 32'h103, 32'h0000_00A5); #1;
      check("sb_gnt",   32'(c1_gnt), 32'h1);
      check("sb_hgnt",  32'(h1_gnt), 32'h0);
      check("sb_we",    32'(m1_we), 32'b1000);
      check("sb_addr",  32'(m1_addr), 32'h40);
      check("sb_wdata", m1_wdata, 32'hA5A5_A5A5);
      check("sb_mis",   32'(c1_mis), 32'h0);

      // Core sh 0xBEEF to 0x106
      next_cycle(); core_acc(1'b1, 2'b01, 32'h106, 32'h1234_BEEF); #1;
      check("sh_we",    32'(m1_we), 32'b1100);
      check("sh_addr",  32'(m1_addr), 32'h41);
      check("sh_wdata", m1_wdata, 32'hBEEF_BEEF);

      // Host write be=0110 0x11223344 to 0x8
      next_cycle(); host_acc(1'b1, 4'b0110, 32'h8, 32'h1122_3344); #1;
      check("hw_gnt",   32'(h1_gnt), 32'h1);
      check("hw_cgnt",  32'(c1_gnt), 32'h0);
      check("hw_we",    32'(m1_we), 32'b0110);
      check("hw_addr",  32'(m1_addr), 32'h2);
      check("hw_wdata", m1_wdata, 32'h1122_3344);

      // Idle: no write, address holds
      next_cycle(); #1;
      check("idle_we",   32'(m1_we), 32'h0);
      check("idle_addr", 32'(m1_addr), 32'h2);

      // Host read of 0x8
      next_cycle(); host_acc(1'b0, 4'h0, 32'h8, 32'h0); #1;
      check("hr_gnt", 32'(h1_gnt), 32'h1);
      next_cycle(); #1;
      check("hr_rvalid", 32'(h1_rvalid), 32'h1);
      check("hr_rdata",  h1_rdata, 32'hD122_3322);
      check("hr_crv",    32'(c1_rvalid), 32'h0);

      // Both request loads for three cycles; core favoured first
      next_cycle(); core_acc(1'b0, 2'b10, 32'h10, 0); host_acc(1'b0, 4'h0, 32'h20, 0); #1;
      check("rr1_cgnt", 32'(c1_gnt), 32'h1);
      check("rr1_hgnt", 32'(h1_gnt), 32'h0);
      check("rr1_addr", 32'(m1_addr), 32'h4);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h14, 0); host_acc(1'b0, 4'h0, 32'h20, 0); #1;
      check("rr2_cgnt", 32'(c1_gnt), 32'h0);
      check("rr2_hgnt", 32'(h1_gnt), 32'h1);
      check("rr2_addr", 32'(m1_addr), 32'h8);
      check("rr2_crv",  32'(c1_rvalid), 32'h1);
      check("rr2_crd",  c1_rdata, 32'hD15C_0444);
      check("rr2_hrv",  32'(h1_rvalid), 32'h0);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h14, 0); host_acc(1'b0, 4'h0, 32'h24, 0); #1;
      check("rr3_cgnt", 32'(c1_gnt), 32'h1);
      check("rr3_hgnt", 32'(h1_gnt), 32'h0);
      check("rr3_hrv",  32'(h1_rvalid), 32'h1);
      check("rr3_hrd",  h1_rdata, 32'hD15C_0888);
      check("rr3_crv",  32'(c1_rvalid), 32'h0);
      next_cycle(); #1;
      check("rr4_crv",  32'(c1_rvalid), 32'h1);
      check("rr4_crd",  c1_rdata, 32'hD15C_0555);
      check("rr4_hrv",  32'(h1_rvalid), 32'h0);
      check("rr4_hold", h1_rdata, 32'hD15C_0888);

      // Misaligned sw to 0x102, then misaligned lw, then aligned reads
      next_cycle(); core_acc(1'b1, 2'b10, 32'h102, 32'hDEAD_BEEF); #1;
      check("msw_gnt", 32'(c1_gnt), 32'h1);
      check("msw_mis", 32'(c1_mis), 32'h1);
      check("msw_we",  32'(m1_we), 32'h0);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h102, 0); #1;
      check("mlw_gnt", 32'(c1_gnt), 32'h1);
      check("mlw_mis", 32'(c1_mis), 32'h1);
      check("msw_nrv", 32'(c1_rvalid), 32'h0);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h100, 0); #1;
      check("mlw_mis0", 32'(c1_mis), 32'h0);
      check("mlw_rv",   32'(c1_rvalid), 32'h1);
      check("mlw_rd",   c1_rdata, 32'h0);
      next_cycle(); core_acc(1'b0, 2'b11, 32'h104, 0); #1;
      check("lw40_rv", 32'(c1_rvalid), 32'h1);
      check("lw40_rd", c1_rdata, 32'hA55C_4440);
      next_cycle(); #1;
      check("lw41_rv", 32'(c1_rvalid), 32'h1);
      check("lw41_rd", c1_rdata, 32'hBEEF_4551);
      next_cycle(); #1;
      check("end_rv",   32'(c1_rvalid), 32'h0);
      check("end_hold", c1_rdata, 32'hBEEF_4551);

      // Load then reset: its return must be flushed
      next_cycle(); core_acc(1'b0, 2'b10, 32'h10, 0); #1;
      check("fl_gnt", 32'(c1_gnt), 32'h1);
      next_cycle(); rst_n = 1'b0; #1;
      check("fl_rv",    32'(c1_rvalid), 32'h0);
      check("fl_rd",    c1_rdata, 32'h0);
      check("fl_hrd",   h1_rdata, 32'h0);
      check("fl_addr",  32'(m1_addr), 32'h0);
      check("fl_wdata", m1_wdata, 32'h0);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h10, 0); #1;
      check("fl2_gnt",  32'(c1_gnt), 32'h0);
      check("fl2_we",   32'(m1_we), 32'h0);
      check("fl2_rv2",  32'(c2_rvalid), 32'h0);
      check("fl2_rd2",  c2_rdata, 32'h0);
      check("fl2_w2",   m2_wdata, 32'h0);
      next_cycle(); rst_n = 1'b1; #1;
      check("fl3_rv",  32'(c1_rvalid), 32'h0);
      check("fl3_rv2", 32'(c2_rvalid), 32'h0);
      next_cycle(); #1;
      check("fl4_rv",  32'(c1_rvalid), 32'h0);

      // Four back-to-back core loads: words 0,1,3,4
      next_cycle(); core_acc(1'b0, 2'b10, 32'h0, 0); #1;
      check("b0_gnt2",  32'(c2_gnt), 32'h1);
      check("b0_addr2", 32'(m2_addr), 32'h0);
      check("b0_rv2",   32'(c2_rvalid), 32'h0);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h4, 0); #1;
      check("b1_gnt2",  32'(c2_gnt), 32'h1);
      check("b1_addr2", 32'(m2_addr), 32'h1);
      check("b1_rv2",   32'(c2_rvalid), 32'h0);
      check("b1_rv1",   32'(c1_rvalid), 32'h1);
      check("b1_rd1",   c1_rdata, 32'hD15C_0000);
      next_cycle(); core_acc(1'b0, 2'b10, 32'hC, 0); #1;
      check("b2_rv2",  32'(c2_rvalid), 32'h1);
      check("b2_rd2",  c2_rdata, 32'hD15C_0000);
      check("b2_rd1",  c1_rdata, 32'hD15C_0111);
      next_cycle(); core_acc(1'b0, 2'b10, 32'h10, 0); #1;
      check("b3_rv2",  32'(c2_rvalid), 32'h1);
      check("b3_rd2",  c2_rdata, 32'hD15C_0111);
      check("b3_rd1",  c1_rdata, 32'hD15C_0333);
      check("b3_mis2", 32'(c2_mis), 32'h0);
      next_cycle(); #1;
      check("b4_rv2",  32'(c2_rvalid), 32'h1);
      check("b4_rd2",  c2_rdata, 32'hD15C_0333);
      check("b4_rd1",  c1_rdata, 32'hD15C_0444);
      check("b4_we2",  32'(m2_we), 32'h0);
      next_cycle(); #1;
      check("b5_rv2",  32'(c2_rvalid), 32'h1);
      check("b5_rd2",  c2_rdata, 32'hD15C_0444);
      check("b5_rv1",  32'(c1_rvalid), 32'h0);
      check("b5_hrv2", 32'(h2_rvalid), 32'h0);
      check("b5_hg2",  32'(h2_gnt), 32'h0);
      check("b5_hrd2", h2_rdata, 32'h0);
      next_cycle(); #1;
      check("b6_rv2",  32'(c2_rvalid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dmem_port_arbiter
